// File: rtl/rvc_mem_loader_pkg.sv
// Shared constants and state type for the RVC program loader.
// Holds memory map limits and the loader FSM state encoding.
package param_pkg;

    localparam logic [31:0] I_MEM_MSB = 32'h0000_0FFF;
    localparam logic [31:0] D_MEM_MSB = 32'h0000_1FFF;

    typedef enum logic [2:0] {
        S_ADDR,
        S_LEN,
        S_DATA,
        S_DONE,
        S_ERR
    } t_loader_state;

endpackage

// File: rtl/rvc_mem_loader_word_asm.sv
// Little-endian 4-byte collector with a 2-bit byte count.
// Ports: clk, clr (sync clear), load (take byte_in), byte_in,
//        word_nxt (word including byte_in), last (4th byte taken).
module rvc_loader_word_asm (
    input  logic        clk,
    input  logic        clr,
    input  logic        load,
    input  logic [7:0]  byte_in,
    output logic [31:0] word_nxt,
    output logic        last
);

    logic [31:0] word_q, word_d;
    logic [1:0]  cnt_q, cnt_d;

    always_comb begin
        word_nxt = word_q;
        unique case (cnt_q)
            2'd0: word_nxt[7:0]   = byte_in;
            2'd1: word_nxt[15:8]  = byte_in;
            2'd2: word_nxt[23:16] = byte_in;
            2'd3: word_nxt[31:24] = byte_in;
        endcase
        word_d = load ? word_nxt : word_q;
        // count wraps 3->0 so the next phase starts clean
        cnt_d  = load ? cnt_q + 2'd1 : cnt_q;
        last   = load && (cnt_q == 2'd3);
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            word_q <= '0;
            cnt_q  <= '0;
        end else begin
            word_q <= word_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/rvc_mem_loader.sv
// Streaming program loader: parses ADDR/LEN/payload frames and writes bytes to memory.
// Ports: Clock, Rst, InValid/InData/InReady byte stream, MemWr* byte write port,
//        CoreRst (held until end frame), LoadDone, LoadErr.
module rvc_mem_loader #(
    parameter logic [31:0] I_MEM_MSB = param_pkg::I_MEM_MSB,
    parameter logic [31:0] D_MEM_MSB = param_pkg::D_MEM_MSB
) (
    input  logic        Clock,
    input  logic        Rst,
    input  logic        InValid,
    input  logic [7:0]  InData,
    output logic        InReady,
    output logic        MemWrEn,
    output logic [31:0] MemWrAddr,
    output logic [7:0]  MemWrData,
    output logic        MemWrIMem,
    output logic        CoreRst,
    output logic        LoadDone,
    output logic        LoadErr
);

    import param_pkg::*;

    t_loader_state state_q, state_d;
    logic [31:0]   ptr_q, ptr_d;
    logic [31:0]   rem_q, rem_d;
    logic          wr_en_q, wr_en_d;
    logic [31:0]   wr_addr_q, wr_addr_d;
    logic [7:0]    wr_data_q, wr_data_d;
    logic          wr_imem_q, wr_imem_d;

    logic          acc;
    logic          addr_ld, len_ld;
    logic          addr_last, len_last;
    logic [31:0]   addr_word, len_word;
    logic [32:0]   end_sum;

    assign InReady = !Rst && (state_q == S_ADDR || state_q == S_LEN || state_q == S_DATA);
    assign acc     = InValid && InReady;
    assign addr_ld = acc && (state_q == S_ADDR);
    assign len_ld  = acc && (state_q == S_LEN);

    rvc_loader_word_asm u_addr_asm (
        .clk      (Clock),
        .clr      (Rst),
        .load     (addr_ld),
        .byte_in  (InData),
        .word_nxt (addr_word),
        .last     (addr_last)
    );

    rvc_loader_word_asm u_len_asm (
        .clk      (Clock),
        .clr      (Rst),
        .load     (len_ld),
        .byte_in  (InData),
        .word_nxt (len_word),
        .last     (len_last)
    );

    // 33-bit so an address near 2^32 cannot wrap past the range check
    assign end_sum = {1'b0, ptr_q} + {1'b0, len_word};

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        rem_d     = rem_q;
        wr_en_d   = 1'b0;
        wr_addr_d = '0;
        wr_data_d = '0;
        wr_imem_d = 1'b0;
        unique case (state_q)
            S_ADDR: begin
                if (addr_last) begin
                    ptr_d   = addr_word;
                    state_d = S_LEN;
                end
            end
            S_LEN: begin
                if (len_last) begin
                    if (len_word == 32'd0) begin
                        state_d = S_DONE;
                    end else if (end_sum > {1'b0, D_MEM_MSB} + 33'd1) begin
                        state_d = S_ERR;
                    end else begin
                        rem_d   = len_word;
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (acc) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = ptr_q;
                    wr_data_d = InData;
                    wr_imem_d = (ptr_q <= I_MEM_MSB);
                    ptr_d     = ptr_q + 32'd1;
                    rem_d     = rem_q - 32'd1;
                    if (rem_q == 32'd1) begin
                        state_d = S_ADDR;
                    end
                end
            end
            S_DONE, S_ERR: begin
                state_d = state_q;
            end
            default: begin
                state_d = S_ADDR;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Rst) begin
            state_q   <= S_ADDR;
            ptr_q     <= '0;
            rem_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wr_imem_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            rem_q     <= rem_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            wr_imem_q <= wr_imem_d;
        end
    end

    assign MemWrEn   = wr_en_q;
    assign MemWrAddr = wr_addr_q;
    assign MemWrData = wr_data_q;
    assign MemWrIMem = wr_imem_q;
    assign CoreRst   = Rst || (state_q != S_DONE);
    assign LoadDone  = !Rst && (state_q == S_DONE);
    assign LoadErr   = !Rst && (state_q == S_ERR);

endmodule

// File: doc/rvc_mem_loader.md
# rvc_mem_loader

Streaming program loader that sits directly upstream of the RVC memory wrapper and core. It accepts a byte stream of load frames (address, length, payload) over a valid/ready handshake, writes the payload bytes into instruction/data memory through a byte write port, and holds the core in reset until an end frame arrives. This replaces backdoor memory forcing, so the same image can be loaded in simulation and on silicon.

## Interface
Parameters:
- I_MEM_MSB, 'h0FFF, last byte address of instruction memory
- D_MEM_MSB, 'h1FFF, last byte address of data memory; valid load range is 0..D_MEM_MSB

Ports:
- Clock  in  1  single clock; all logic on posedge
- Rst  in  1  reset, synchronous, active-high
- InValid  in  1  input byte valid
- InData  in  8  input byte
- InReady  out  1  loader accepts the byte this cycle
- MemWrEn  out  1  byte write strobe
- MemWrAddr  out  32  byte address
- MemWrData  out  8  write byte
- MemWrIMem  out  1  1 = address is in IMem (MemWrAddr <= I_MEM_MSB), 0 = DMem
- CoreRst  out  1  reset to core; 1 until end frame accepted
- LoadDone  out  1  end frame accepted, sticky until Rst
- LoadErr  out  1  range error, sticky until Rst

## Operation
- Frame format: ADDR (4 bytes, little-endian), LEN (4 bytes, little-endian), then LEN payload bytes. A frame with LEN=0 is the end frame; its ADDR is ignored.
- A byte is accepted when InValid && InReady.
- States:
  - S_ADDR: collects 4 bytes, then goes to S_LEN.
  - S_LEN: collects 4 bytes, then:
    - LEN=0 -> S_DONE.
    - ADDR+LEN (33-bit sum) > D_MEM_MSB+1 -> S_ERR.
    - otherwise -> S_DATA.
  - S_DATA: each accepted byte is written to the current address, the address increments by 1 and the remaining count decrements. After the last byte -> S_ADDR (the next frame).
  - S_DONE: terminal until Rst.
  - S_ERR: terminal until Rst.
- InReady = 1 in S_ADDR, S_LEN and S_DATA; 0 in S_DONE and S_ERR.
- Memory never back-pressures; every accepted payload byte produces exactly one write.
- S_DONE: LoadDone=1, CoreRst=0. S_ERR: LoadErr=1, CoreRst stays 1.
- Byte counters are 2 bits and wrap 3->0 on the phase change. The remaining-payload counter is 32 bits.

## Timing
- Reset values: InReady=0 during the Rst cycle, then 1 from the first cycle after. MemWrEn=0, MemWrAddr=0, MemWrData=0, MemWrIMem=0, CoreRst=1, LoadDone=0, LoadErr=0. State is S_ADDR with all counters 0.
- Write latency: a payload byte accepted at edge t produces MemWrEn=1 with its address and data during cycle t+1, for one cycle. Back-to-back accepted bytes give back-to-back writes.
- The end frame's 4th LEN byte is accepted at edge t; from cycle t+1 CoreRst=0 and LoadDone=1.
- An error is decided on the 4th LEN byte; LoadErr=1 from t+1 and no write is issued for that frame.
- InValid low stalls any phase with no state change and no writes.
- Rst mid-frame: returns to S_ADDR next cycle, CoreRst=1, flags cleared. Bytes already written are not undone.
- The final payload byte at address D_MEM_MSB is legal and must not trigger an error (boundary ADDR+LEN == D_MEM_MSB+1).

## Structure
- param_pkg holds I_MEM_MSB, D_MEM_MSB and the typedef enum t_loader_state {S_ADDR, S_LEN, S_DATA, S_DONE, S_ERR}.
- One sub-module, rvc_loader_word_asm: a 4-byte little-endian collector with load, clear and a 2-bit count, instantiated twice (ADDR, LEN).
- Flops use the codebase MSFF macros with synchronous reset.

## Test plan
- Frame ADDR=0x0, LEN=4, data 13 00 00 00, then end frame -> writes at 0..3 with MemWrIMem=1. CoreRst falls 1 cycle after the last end-frame byte; LoadDone=1.
- Frame ADDR=0x1000, LEN=2 (AA, BB) with InValid toggling every other cycle -> exactly 2 writes: 0x1000=AA, 0x1001=BB, MemWrIMem=0, each 1 cycle after its accept.
- Frame ADDR=0x1FFE, LEN=2 -> writes 0x1FFE and 0x1FFF, no error. Frame ADDR=0x1FFF, LEN=2 -> LoadErr=1, InReady=0, no writes, CoreRst stays 1.
- Two consecutive frames (ADDR=0x10, LEN=1; ADDR=0x1004, LEN=1), then end frame -> 2 writes in order, then LoadDone=1.
- Assert Rst after 5 bytes of a frame -> S_ADDR, CoreRst=1. A new full frame loads correctly at its own address.
- ADDR=0xFFFFFFFF, LEN=2 -> 33-bit sum detects overflow, so LoadErr=1.
